// File: rtl/riscv_muldiv_unit_pkg.sv
// riscv_muldiv_pkg: funct3 encodings, FSM states and op classification for the M-extension unit.
package riscv_muldiv_pkg;
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {IDLE, MUL, DIV_SETUP, DIV_ITER, DIV_FIX, DONE} state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return op == OP_DIV || op == OP_REM;
    endfunction
endpackage

// File: rtl/riscv_muldiv_unit_if.sv
// riscv_muldiv_unit_if: request/response bundle between the EX stage and the mul/div unit.
interface riscv_muldiv_unit_if #(parameter int XLEN = 32);
    logic            iStart;
    logic [2:0]      iOp;
    logic [XLEN-1:0] iA;
    logic [XLEN-1:0] iB;
    logic            iFlush;
    logic            oBusy;
    logic            oValid;
    logic [XLEN-1:0] oResult;
    logic            oDivByZero;

    modport master (output iStart, iOp, iA, iB, iFlush, input oBusy, oValid, oResult, oDivByZero);
    modport slave  (input iStart, iOp, iA, iB, iFlush, output oBusy, oValid, oResult, oDivByZero);
endinterface

// File: rtl/riscv_muldiv_unit_div_iter_core.sv
// div_iter_core: restoring divider on unsigned magnitudes; each iStep retires one (or two) quotient bits.
module div_iter_core #(
    parameter int XLEN   = 32,
    parameter bit RADIX4 = 1'b0
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iLoad,
    input  logic            iStep,
    input  logic [XLEN-1:0] iDividend,
    input  logic [XLEN-1:0] iDivisor,
    output logic [XLEN-1:0] oQuot,
    output logic [XLEN-1:0] oRem
);
    logic [2*XLEN-1:0] remQuot, stepOnce, stepTwice;
    logic [XLEN-1:0]   divisor;

    // {rem, quot} shift left; keep the trial subtraction only if it did not borrow
    function automatic logic [2*XLEN-1:0] divStep(input logic [2*XLEN-1:0] rq, input logic [XLEN-1:0] d);
        logic [XLEN:0] sh, diff;
        sh   = rq[2*XLEN-1:XLEN-1];
        diff = sh - {1'b0, d};
        return diff[XLEN] ? {sh[XLEN-1:0], rq[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], rq[XLEN-2:0], 1'b1};
    endfunction

    assign stepOnce  = divStep(remQuot, divisor);
    assign stepTwice = divStep(stepOnce, divisor);
    assign oQuot     = remQuot[XLEN-1:0];
    assign oRem      = remQuot[2*XLEN-1:XLEN];

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            remQuot <= '0;
            divisor <= '0;
        end else if (iLoad) begin
            remQuot <= {{XLEN{1'b0}}, iDividend};
            divisor <= iDivisor;
        end else if (iStep) begin
            remQuot <= RADIX4 ? stepTwice : stepOnce;
        end
    end
endmodule

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit beside the EX-stage ALU.
// Multiplies through a fixed-latency product pipe; divides iteratively with early-outs for /0 and MIN/-1.
module riscv_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter bit DIV_RADIX4  = 1'b0
) (
    input logic               iCLK,
    input logic               iRST,
    riscv_muldiv_unit_if.slave bus
);
    localparam int ITERS = DIV_RADIX4 ? XLEN / 2 : XLEN;
    localparam int CW    = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   MUL_LAST  = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0]   ITER_LAST = CW'(ITERS - 1);
    localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

    state_t                   state, nextState;
    logic [CW-1:0]            cnt;
    logic [2:0]               op;
    logic [XLEN-1:0]          opA, opB, result, nextResult, quot, rem, quotFix, remFix;
    logic                     divByZero, accept, overflow, early;
    logic signed [XLEN:0]     aExt, bExt;
    logic signed [2*XLEN-1:0] product;
    logic [2*XLEN-1:0]        mulPipe [MUL_LATENCY];

    assign accept   = bus.iStart && !bus.iFlush && (state == IDLE || state == DONE);
    // (XLEN+1)-bit signed operands cover all three sign modes with one multiplier
    assign aExt     = {bus.iA[XLEN-1] & (bus.iOp == OP_MULH || bus.iOp == OP_MULHSU), bus.iA};
    assign bExt     = {bus.iB[XLEN-1] & (bus.iOp == OP_MULH), bus.iB};
    assign product  = (2*XLEN)'(aExt) * (2*XLEN)'(bExt);
    assign overflow = is_signed(op) && opA == MIN_INT && opB == '1;
    assign early    = opB == '0 || overflow;
    assign quotFix  = is_signed(op) && (opA[XLEN-1] ^ opB[XLEN-1]) ? -quot : quot;
    assign remFix   = is_signed(op) && opA[XLEN-1] ? -rem : rem;

    div_iter_core #(.XLEN(XLEN), .RADIX4(DIV_RADIX4)) uDiv (
        .iCLK,
        .iRST,
        .iLoad     (state == DIV_SETUP),
        .iStep     (state == DIV_ITER),
        .iDividend (is_signed(op) && opA[XLEN-1] ? -opA : opA),
        .iDivisor  (is_signed(op) && opB[XLEN-1] ? -opB : opB),
        .oQuot     (quot),
        .oRem      (rem)
    );

    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: nextState = bus.iStart ? (is_div(bus.iOp) ? DIV_SETUP : MUL) : IDLE;
            MUL:        nextState = cnt == MUL_LAST ? DONE : MUL;
            DIV_SETUP:  nextState = early ? DONE : DIV_ITER;
            DIV_ITER:   nextState = cnt == ITER_LAST ? DIV_FIX : DIV_ITER;
            DIV_FIX:    nextState = DONE;
            default:    nextState = IDLE;
        endcase
        if (bus.iFlush) nextState = IDLE;
        nextResult = state == MUL ? (op == OP_MUL ? mulPipe[MUL_LATENCY-1][XLEN-1:0]
                                                  : mulPipe[MUL_LATENCY-1][2*XLEN-1:XLEN])
                   : state == DIV_FIX ? (op[1] ? remFix : quotFix)
                   : opB == '0 ? (op[1] ? opA : '1)
                   : (op[1] ? '0 : opA);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            opA       <= '0;
            opB       <= '0;
            result    <= '0;
            divByZero <= 1'b0;
            for (int i = 0; i < MUL_LATENCY; i++) mulPipe[i] <= '0;
        end else begin
            state <= nextState;
            cnt   <= (state == MUL || state == DIV_ITER) && nextState == state ? cnt + CW'(1) : '0;
            if (accept) begin
                op  <= bus.iOp;
                opA <= bus.iA;
                opB <= bus.iB;
            end
            if (nextState == DONE && state != DONE) begin
                result    <= nextResult;
                divByZero <= state == DIV_SETUP && opB == '0;
            end
            mulPipe[0] <= accept ? product : mulPipe[0];
            for (int i = 1; i < MUL_LATENCY; i++) mulPipe[i] <= mulPipe[i-1];
        end
    end

    assign bus.oBusy      = state != IDLE && state != DONE;
    assign bus.oValid     = state == DONE;
    assign bus.oResult    = result;
    assign bus.oDivByZero = divByZero;
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb_riscv_muldiv_unit: directed vectors checked against an arithmetic reference model every cycle.
module tb_riscv_muldiv_unit;
    import riscv_muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = 2;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    int   nChecks = 0;
    int   nFails = 0;
    int   validCnt = 0;

    riscv_muldiv_unit_if #(.XLEN(XLEN)) bus();

    riscv_muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(LAT), .DIV_RADIX4(1'b0)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: result, divide-by-zero flag and accept-to-valid latency from plain arithmetic
    function automatic void golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic dbz, output int lat);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic isRem, isSgn;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        isRem = op == OP_REM || op == OP_REMU;
        isSgn = op == OP_DIV || op == OP_REM;
        dbz = 1'b0;
        lat = LAT;
        p = '0;
        case (op)
            OP_MUL:    begin p = sa * sb; r = p[31:0];  end
            OP_MULH:   begin p = sa * sb; r = p[63:32]; end
            OP_MULHSU: begin p = sa * ua; r = p[63:32]; end
            OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
            default: begin
                lat = XLEN + 2;
                if (b == 0) begin
                    lat = 1;
                    dbz = 1'b1;
                    r = isRem ? a : 32'hFFFF_FFFF;
                end else if (isSgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lat = 1;
                    r = isRem ? 32'h0 : a;
                end else begin
                    if (op == OP_DIV) p = sa / sb;
                    else if (op == OP_DIVU) p = ua / ub;
                    else if (op == OP_REM) p = sa % sb;
                    else p = ua % ub;
                    r = p[31:0];
                end
            end
        endcase
    endfunction

    logic        mPend = 1'b0, mValid = 1'b0, mDbz = 1'b0, pDbz;
    logic [31:0] mRes = '0, pRes;
    int          mLeft = 0;

    always @(posedge iCLK) begin
        if (iRST) begin
            mPend = 1'b0;
            mValid = 1'b0;
            mRes = '0;
            mDbz = 1'b0;
        end else begin
            mValid = 1'b0;
            if (mPend) begin
                if (bus.iFlush) mPend = 1'b0;
                else begin
                    mLeft--;
                    if (mLeft == 0) begin
                        mPend = 1'b0;
                        mValid = 1'b1;
                        mRes = pRes;
                        mDbz = pDbz;
                    end
                end
            end else if (bus.iStart && !bus.iFlush) begin
                golden(bus.iOp, bus.iA, bus.iB, pRes, pDbz, mLeft);
                mPend = 1'b1;
            end
        end
        #1;
        check("busy", bus.oBusy, mPend);
        check("valid", bus.oValid, mValid);
        check("result", bus.oResult, mRes);
        if (mValid) check("divbyzero", bus.oDivByZero, mDbz);
    end

    always @(negedge iCLK) if (bus.oValid === 1'b1) validCnt++;

    // Caller is at a negedge; leaves at the negedge of the oValid cycle so the next call can go back-to-back
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expR, input int expLat, input string name);
        int k = 0;
        bus.iStart = 1'b1;
        bus.iOp = op;
        bus.iA = a;
        bus.iB = b;
        do begin
            @(negedge iCLK);
            k++;
            if (k == 1) bus.iStart = 1'b0;
        end while (bus.oValid !== 1'b1 && k < 100);
        check({name, " latency"}, k - 1, expLat);
        check({name, " value"}, bus.oResult, expR);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, k;
        bus.iStart = 1'b0;
        bus.iOp = '0;
        bus.iA = '0;
        bus.iB = '0;
        bus.iFlush = 1'b0;
        repeat (2) @(negedge iCLK);
        check("reset busy", bus.oBusy, 0);
        check("reset valid", bus.oValid, 0);
        check("reset result", bus.oResult, 0);
        check("reset dbz", bus.oDivByZero, 0);
        iRST = 1'b0;

        run(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, "mulh min*min");
        run(OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 2, "mul min*min");
        run(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div -7/2");
        check("div -7/2 dbz", bus.oDivByZero, 0);
        run(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem -7/2");
        run(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu 5/0");
        check("divu 5/0 dbz", bus.oDivByZero, 1);
        run(OP_REM,    32'd5,         32'd0,         32'd5,         1, "rem 5/0");
        run(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div overflow");
        check("div overflow dbz", bus.oDivByZero, 0);
        run(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "rem overflow");
        run(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu max");
        run(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mulhsu -1*max");
        run(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "mul 7*-3");
        run(OP_MULH,   32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF, 2, "mulh -1*5");
        run(OP_DIVU,   32'd100,       32'd7,         32'd14,        34, "divu 100/7");
        run(OP_REMU,   32'd100,       32'd7,         32'd2,         34, "remu 100/7");
        run(OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div 7/-2");
        run(OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34, "rem 7/-2");
        run(OP_DIV,    32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4,         34, "div -8/-2");
        run(OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, "divu min/max");
        run(OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "remu min/max");
        run(OP_DIV,    32'h8000_0000, 32'd1,         32'h8000_0000, 34, "div min/1");
        run(OP_REM,    32'h8000_0000, 32'd1,         32'd0,         34, "rem min/1");
        run(OP_REMU,   32'd9,         32'd0,         32'd9,         1, "remu 9/0");

        // Flush mid-divide, then one multiply: exactly one oValid
        repeat (2) @(negedge iCLK);
        v0 = validCnt;
        bus.iStart = 1'b1;
        bus.iOp = OP_DIVU;
        bus.iA = 32'd100;
        bus.iB = 32'd7;
        @(negedge iCLK);
        bus.iStart = 1'b0;
        repeat (6) @(negedge iCLK);
        bus.iFlush = 1'b1;
        @(negedge iCLK);
        bus.iFlush = 1'b0;
        check("flush busy", bus.oBusy, 0);
        run(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu after flush");
        repeat (40) @(negedge iCLK);
        check("flush valid count", validCnt - v0, 1);

        // Flush and start together in IDLE: request dropped
        v0 = validCnt;
        bus.iStart = 1'b1;
        bus.iFlush = 1'b1;
        bus.iOp = OP_MUL;
        bus.iA = 32'd3;
        bus.iB = 32'd4;
        @(negedge iCLK);
        bus.iStart = 1'b0;
        bus.iFlush = 1'b0;
        check("flush+start busy", bus.oBusy, 0);
        repeat (5) @(negedge iCLK);
        check("flush+start valid count", validCnt - v0, 0);

        // Start while busy is ignored
        v0 = validCnt;
        bus.iStart = 1'b1;
        bus.iOp = OP_DIVU;
        bus.iA = 32'd100;
        bus.iB = 32'd7;
        k = 0;
        do begin
            @(negedge iCLK);
            k++;
            bus.iStart = k == 3;
            bus.iOp = k == 3 ? OP_MUL : OP_DIVU;
            bus.iA = k == 3 ? 32'd3 : 32'd100;
            bus.iB = k == 3 ? 32'd3 : 32'd7;
        end while (bus.oValid !== 1'b1 && k < 100);
        check("busy-start latency", k - 1, 34);
        check("busy-start value", bus.oResult, 14);
        repeat (5) @(negedge iCLK);
        check("busy-start valid count", validCnt - v0, 1);

        // Reset at divide iteration 10
        bus.iStart = 1'b1;
        bus.iOp = OP_DIV;
        bus.iA = 32'hFFFF_FFF9;
        bus.iB = 32'd2;
        @(negedge iCLK);
        bus.iStart = 1'b0;
        repeat (11) @(negedge iCLK);
        iRST = 1'b1;
        #1;
        check("mid-div reset busy", bus.oBusy, 0);
        check("mid-div reset result", bus.oResult, 0);
        check("mid-div reset valid", bus.oValid, 0);
        @(negedge iCLK);
        iRST = 1'b0;
        v0 = validCnt;
        repeat (50) @(negedge iCLK);
        check("mid-div reset valid count", validCnt - v0, 0);
        run(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu after reset");

        repeat (2) @(negedge iCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
